// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage. Holds the program counter and drives it to a combinational
//   instruction ROM. The returned word is registered for the decode stage.
//   The PC steps by 4. Execute can redirect it, and decode back-pressure
//   stalls it. A redirect to a target that is not word-aligned is treated as
//   a fatal fault: the stage halts until reset and raises a sticky flag.
//
// Ports
//   clk_i            rising-edge clock
//   rst_n_i          asynchronous active-low reset
//   imem_addr_o      ROM byte address (the current PC)
//   imem_data_i      ROM read data, combinational from imem_addr_o
//   stall_i          decode not ready: hold the fetch register and the PC
//   redirect_valid_i load redirect_pc_i into the PC and flush (beats stall_i)
//   redirect_pc_i    redirect target
//   instr_valid_o    instr_o/pc_o carry a valid fetched instruction
//   instr_o          registered instruction (NOP_INSTR while invalid)
//   pc_o             address instr_o was fetched from
//   pc_plus4_o       pc_o + 4, wrapping modulo 2^ADDR_WIDTH
//   misaligned_o     sticky misaligned-redirect fault
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 8'h00,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q,    pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   pco_q,   pco_d;
  logic                    vld_q,   vld_d;
  logic                    mis_q,   mis_d;

  logic                    redir_misaligned;

  assign redir_misaligned = (redirect_pc_i[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pco_q   <= '0;
      vld_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      vld_q   <= vld_d;
      mis_q   <= mis_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Everything holds by default. That default covers stall,
  // BOOT (redirects ignored, outputs still invalid) and HALT (frozen).
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    vld_d   = vld_q;
    mis_d   = mis_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (redirect_valid_i) begin
          // The redirect wins over stall. The instruction in the fetch register
          // is from the wrong path, so replace it with a bubble. pc_o keeps
          // its last value. It is meaningless while instr_valid_o is low.
          pc_d    = redirect_pc_i;
          vld_d   = 1'b0;
          instr_d = NOP_INSTR;
          if (redir_misaligned) begin
            // The faulting target stays in pc_q so it can be inspected.
            mis_d   = 1'b1;
            state_d = HALT;
          end
        end else if (!stall_i) begin
          instr_d = imem_data_i;
          pco_d   = pc_q;
          vld_d   = 1'b1;
          pc_d    = pc_q + PC_STEP;
        end
      end

      HALT: begin
        // HALT is only entered through a flush, so vld_q is already 0.
        // Forcing it here keeps that true even if the way in ever changes.
        vld_d = 1'b0;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = vld_q;
  assign instr_o       = instr_q;
  assign pc_o          = pco_q;
  assign pc_plus4_o    = pco_q + PC_STEP;
  assign misaligned_o  = mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. The ROM returns
//   32'hA000_0000 | addr. The bench has three parts: a directed vector table,
//   hand-written corner sequences (wrap, async reset mid-run, misaligned halt)
//   and random stimulus. A behavioural model checks every cycle.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam logic [DW-1:0] NOP = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          stall;
  logic          redir;
  logic [AW-1:0] redir_pc;
  logic          vld;
  logic [DW-1:0] instr;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc_p4;
  logic          mis;

  int tests;
  int fails;

  instruction_fetch #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (8'h00),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .imem_addr_o      (imem_addr),
    .imem_data_i      (imem_data),
    .stall_i          (stall),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .instr_valid_o    (vld),
    .instr_o          (instr),
    .pc_o             (pc_out),
    .pc_plus4_o       (pc_p4),
    .misaligned_o     (mis)
  );

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return 32'hA000_0000 | {24'h0, a};
  endfunction

  assign imem_data = rom(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   m_boot : the first cycle after reset release is still pending
  //   m_halt : a misaligned redirect has been seen
  // ---------------------------------------------------------------------------
  bit            m_boot, m_halt, m_vld, m_mis;
  logic [AW-1:0] m_pc, m_pco;
  logic [DW-1:0] m_instr;

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_vld = 1'b0; m_mis = 1'b0;
    m_pc = 8'h00; m_pco = 8'h00; m_instr = NOP;
  endtask

  task automatic model_cycle(input bit s, input bit r, input logic [AW-1:0] rpc);
    if (m_halt) return;
    if (m_boot) begin m_boot = 1'b0; return; end
    if (r) begin
      m_pc = rpc; m_vld = 1'b0; m_instr = NOP;
      if (rpc % 4 != 0) begin m_mis = 1'b1; m_halt = 1'b1; end
    end else if (!s) begin
      m_instr = rom(m_pc); m_pco = m_pc; m_vld = 1'b1;
      m_pc = AW'((int'(m_pc) + 4) % 256);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".addr"},  32'(imem_addr), 32'(m_pc));
    chk({tag, ".vld"},   32'(vld),       32'(m_vld));
    chk({tag, ".instr"}, instr,          m_instr);
    chk({tag, ".mis"},   32'(mis),       32'(m_mis));
    if (m_vld) begin
      chk({tag, ".pc_o"},  32'(pc_out), 32'(m_pco));
      chk({tag, ".pc_p4"}, 32'(pc_p4),  (32'(m_pco) + 32'd4) % 32'd256);
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, then check outputs 1ns later.
  task automatic step(input bit s, input bit r, input logic [AW-1:0] rpc, input string tag);
    stall = s; redir = r; redir_pc = rpc;
    model_cycle(s, r, rpc);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rst_addr"},  32'(imem_addr), 32'h00);
    chk({tag, ".rst_vld"},   32'(vld),       32'h0);
    chk({tag, ".rst_instr"}, instr,          NOP);
    chk({tag, ".rst_pc_o"},  32'(pc_out),    32'h00);
    chk({tag, ".rst_mis"},   32'(mis),       32'h0);
  endtask

  // Assert reset between edges, check its effect right away, release on negedge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals(tag);
    model_reset();
    stall = 1'b0; redir = 1'b0; redir_pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            s;
    bit            r;
    logic [AW-1:0] rpc;
    bit            e_vld;
    logic [AW-1:0] e_pco;
    logic [DW-1:0] e_instr;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit s, bit r, logic [AW-1:0] rpc, bit ev,
                              logic [AW-1:0] ep, logic [DW-1:0] ei, logic [AW-1:0] ea);
    vec_t v;
    v.s = s; v.r = r; v.rpc = rpc; v.e_vld = ev; v.e_pco = ep; v.e_instr = ei; v.e_addr = ea;
    return v;
  endfunction

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = '0;
    model_reset();

    //            s  r  rpc    vld pc_o   instr          addr
    vt.push_back(mk(0, 0, 8'h00, 0, 8'h00, NOP,           8'h00)); // BOOT
    vt.push_back(mk(0, 0, 8'h00, 1, 8'h00, 32'hA000_0000, 8'h04));
    vt.push_back(mk(0, 0, 8'h00, 1, 8'h04, 32'hA000_0004, 8'h08));
    vt.push_back(mk(0, 0, 8'h00, 1, 8'h08, 32'hA000_0008, 8'h0C));
    vt.push_back(mk(1, 0, 8'h00, 1, 8'h08, 32'hA000_0008, 8'h0C)); // stall x3
    vt.push_back(mk(1, 0, 8'h00, 1, 8'h08, 32'hA000_0008, 8'h0C));
    vt.push_back(mk(1, 0, 8'h00, 1, 8'h08, 32'hA000_0008, 8'h0C));
    vt.push_back(mk(0, 0, 8'h00, 1, 8'h0C, 32'hA000_000C, 8'h10));
    vt.push_back(mk(0, 1, 8'h40, 0, 8'h0C, NOP,           8'h40)); // redirect while at 10
    vt.push_back(mk(0, 0, 8'h00, 1, 8'h40, 32'hA000_0040, 8'h44));
    vt.push_back(mk(1, 1, 8'h40, 0, 8'h40, NOP,           8'h40)); // redirect beats stall
    vt.push_back(mk(0, 0, 8'h00, 1, 8'h40, 32'hA000_0040, 8'h44));
    vt.push_back(mk(0, 0, 8'h00, 1, 8'h44, 32'hA000_0044, 8'h48));

    repeat (2) @(posedge clk);
    #1 chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].s, vt[i].r, vt[i].rpc, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_vld", i),   32'(vld),       32'(vt[i].e_vld));
      chk($sformatf("vec%0d.t_instr", i), instr,          vt[i].e_instr);
      chk($sformatf("vec%0d.t_addr", i),  32'(imem_addr), 32'(vt[i].e_addr));
      if (vt[i].e_vld) begin
        chk($sformatf("vec%0d.t_pc_o", i),  32'(pc_out), 32'(vt[i].e_pco));
        chk($sformatf("vec%0d.t_pc_p4", i), 32'(pc_p4),  32'(vt[i].e_pco + 8'd4));
      end
    end

    // Wrap: F8, FC, 00, 04
    step(0, 1, 8'hF8, "wrap.redir");
    step(0, 0, 8'h00, "wrap.f8");
    chk("wrap.pc_f8", 32'(pc_out), 32'hF8);
    step(0, 0, 8'h00, "wrap.fc");
    chk("wrap.pc_fc", 32'(pc_out), 32'hFC);
    chk("wrap.p4_00", 32'(pc_p4),  32'h00);
    chk("wrap.addr0", 32'(imem_addr), 32'h00);
    step(0, 0, 8'h00, "wrap.00");
    chk("wrap.pc_00", 32'(pc_out), 32'h00);
    step(0, 0, 8'h00, "wrap.04");
    chk("wrap.pc_04", 32'(pc_out), 32'h04);

    // Async reset mid-run while pc = 30
    step(0, 1, 8'h30, "mrst.redir");
    chk("mrst.addr30", 32'(imem_addr), 32'h30);
    mid_reset("mrst");
    step(0, 0, 8'h00, "mrst.boot");
    chk("mrst.boot_vld", 32'(vld), 32'h0);
    step(0, 0, 8'h00, "mrst.f00");
    chk("mrst.pc00", 32'(pc_out), 32'h00);
    chk("mrst.vld1", 32'(vld),    32'h1);

    // Misaligned redirect: halt and sticky flag
    step(0, 0, 8'h00, "mis.pre");
    step(0, 1, 8'h22, "mis.redir");
    chk("mis.flag", 32'(mis), 32'h1);
    for (int i = 0; i < 12; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           AW'($urandom), $sformatf("mis.hold%0d", i));
      chk($sformatf("mis.hold%0d.flag", i), 32'(mis), 32'h1);
      chk($sformatf("mis.hold%0d.vld", i),  32'(vld), 32'h0);
    end
    mid_reset("mis.clr");
    step(0, 0, 8'h00, "mis.boot");

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      bit            s, r;
      logic [AW-1:0] t;
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 12);
      t = AW'($urandom) & 8'hFC;
      if ($urandom_range(0, 99) < 3) t = t | AW'($urandom_range(1, 3));
      step(s, r, t, $sformatf("rnd%0d", i));
      if (i % 60 == 59) mid_reset($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage that drives the instruction ROM address and registers the returned word for decode. It holds the program counter, issues sequential addresses in steps of 4, accepts redirects (branch/jump) from execute, and stalls on downstream back-pressure. The ROM read is combinational: the address goes out and the data returns in the same cycle. The fetch register supplies one instruction per cycle to the decode stage.

Parameters:
ADDR_WIDTH, 8, width of the PC and the ROM byte address.
DATA_WIDTH, 32, instruction width.
RESET_PC, 8'h00, PC value loaded at reset.
NOP_INSTR, 32'h0000_0013, value of instr_o while invalid or after reset (addi x0,x0,0).

Ports:
clk_i  input  1  rising-edge clock
rst_n_i  input  1  asynchronous active-low reset
imem_addr_o  output  ADDR_WIDTH  byte address to the instruction ROM, equal to pc_q
imem_data_i  input  DATA_WIDTH  ROM read data, combinational from imem_addr_o
stall_i  input  1  decode not ready; hold the current output
redirect_valid_i  input  1  load a new PC from execute
redirect_pc_i  input  ADDR_WIDTH  redirect target
instr_valid_o  output  1  instr_o/pc_o hold a valid fetched instruction
instr_o  output  DATA_WIDTH  registered instruction
pc_o  output  ADDR_WIDTH  address instr_o was fetched from
pc_plus4_o  output  ADDR_WIDTH  pc_o + 4 mod 2^ADDR_WIDTH, combinational from pc_o
misaligned_o  output  1  sticky fault: redirect target not word-aligned

Behaviour:
- Reset is asynchronous, active-low. Values while reset is asserted:
  - pc_q = RESET_PC, so imem_addr_o = RESET_PC
  - instr_valid_o = 0, instr_o = NOP_INSTR, pc_o = 0
  - misaligned_o = 0, state = BOOT
- States:
  - BOOT: lasts exactly 1 cycle after reset release. Outputs stay invalid and pc_q is unchanged. Goes to RUN.
  - RUN: normal fetch.
  - HALT: entered on a misaligned redirect. Left only by reset.
- Fetch in RUN, stall_i=0, no redirect:
  - instr_o <= imem_data_i, pc_o <= pc_q, instr_valid_o <= 1
  - pc_q <= pc_q + 4
  - Latency from address out to instr_valid_o: 1 cycle.
- Stall in RUN, stall_i=1, no redirect:
  - pc_q, instr_o, pc_o and instr_valid_o all hold.
  - Outputs stay bit-stable for as long as stall_i remains high.
- Redirect in RUN, redirect_valid_i=1, target aligned:
  - pc_q <= redirect_pc_i
  - instr_valid_o <= 0 and instr_o <= NOP_INSTR, flushing the wrong-path instruction (one-cycle bubble).
  - Redirect has priority over stall_i. When both are high, the redirect is taken.
- Misaligned redirect (redirect_pc_i[1:0] != 0):
  - misaligned_o <= 1, state <= HALT
  - instr_valid_o <= 0, instr_o <= NOP_INSTR
  - pc_q <= redirect_pc_i (captured for debug).
- HALT: all inputs are ignored, pc_q is frozen and instr_valid_o = 0. misaligned_o stays 1 until reset.
- Redirect in BOOT is ignored.
- Wrap-around: all PC arithmetic is modulo 2^ADDR_WIDTH with no flag. 8'hFC + 4 = 8'h00. pc_plus4_o wraps the same way.
- Reset mid-operation: all state returns to its reset values immediately (asynchronous). Fetch restarts from RESET_PC after the BOOT cycle.
- pc_q[1:0] is always 0 in RUN.

Test Plan:
- Bench ROM model returns 32'hA000_0000 | addr.
- Sequential fetch:
  - Stimulus: release reset, stall=0, no redirect.
  - Response: cycle 1 instr_valid_o=0 (BOOT). From cycle 2, imem_addr_o = 00, 04, 08 ... 20.
  - Each valid output: instr_o = 32'hA000_00xx with pc_o = xx and pc_plus4_o = xx+4.
- Stall hold:
  - Stimulus: stall_i=1 for 3 cycles while pc_o=08.
  - Response: instr_o=32'hA000_0008 and instr_valid_o=1 stay stable, imem_addr_o stays 0C. After release, the next output is pc_o=0C.
- Redirect with flush:
  - Stimulus: pulse redirect_valid_i with redirect_pc_i=8'h40 while fetching 10; repeat the pulse together with stall_i=1.
  - Response: next cycle instr_valid_o=0 and instr_o=NOP, imem_addr_o=40. Following cycle pc_o=40, instr_o=32'hA000_0040. With stall_i=1 the redirect still wins.
- Misaligned redirect:
  - Stimulus: redirect_pc_i=8'h22.
  - Response: misaligned_o=1 and instr_valid_o=0, held for 10+ cycles regardless of inputs. Only reset clears it.
- Wrap:
  - Stimulus: redirect to 8'hF8, then run.
  - Response: pc_o sequence F8, FC, 00, 04. pc_plus4_o=00 when pc_o=FC.
- Reset mid-run:
  - Stimulus: assert rst_n_i=0 asynchronously between clock edges while pc=30.
  - Response: outputs go to their reset values immediately. After release, BOOT runs for one cycle, then fetch starts at 00.
